// File: rtl/cpu_pkg.sv
// Shared definitions for the CR16-style instruction sequencer: state
// encoding, opcode/ext/condition constants, flag bit positions and small
// instruction-field decode helpers used by the FSM.
package cpu_pkg;

   // Sequencer states; the encoding is also exported on the debug port
   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      LOAD_WB = 3'd4,
      BRANCH  = 3'd5,
      HALT    = 3'd6
   } state_t;

   // Primary opcodes (ir[15:12])
   localparam logic [3:0] OP_RTYPE   = 4'b0000;
   localparam logic [3:0] OP_SPECIAL = 4'b0100;
   localparam logic [3:0] OP_BCOND   = 4'b1100;
   localparam logic [3:0] OP_CMPI    = 4'b1011;

   // Extended opcodes (ir[7:4])
   localparam logic [3:0] EXT_WAIT  = 4'b0000;
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;
   localparam logic [3:0] EXT_CMP   = 4'b1011;

   // Condition codes (ir[11:8] of Bcond/Jcond)
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_HI = 4'b0100;
   localparam logic [3:0] COND_LS = 4'b0101;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_UC = 4'b1110;

   // Bit positions inside the 5-bit flag word {C,L,F,Z,N}
   localparam int FLAG_C = 4;
   localparam int FLAG_L = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   // Field extraction
   function automatic logic [3:0] op_of(input logic [15:0] w);
      return w[15:12];
   endfunction

   function automatic logic [3:0] ext_of(input logic [15:0] w);
      return w[7:4];
   endfunction

   // One-hot register select from a 4-bit register number
   function automatic logic [15:0] onehot16(input logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

   function automatic logic is_load(input logic [15:0] w);
      return (op_of(w) == OP_SPECIAL) && (ext_of(w) == EXT_LOAD);
   endfunction

   function automatic logic is_stor(input logic [15:0] w);
      return (op_of(w) == OP_SPECIAL) && (ext_of(w) == EXT_STOR);
   endfunction

   function automatic logic is_jcond(input logic [15:0] w);
      return (op_of(w) == OP_SPECIAL) && (ext_of(w) == EXT_JCOND);
   endfunction

   function automatic logic is_wait(input logic [15:0] w);
      return (op_of(w) == OP_RTYPE) && (ext_of(w) == EXT_WAIT);
   endfunction

   // Any ALU op that takes its B operand from ir[7:0]
   function automatic logic is_imm_alu(input logic [15:0] w);
      return (op_of(w) != OP_RTYPE) && (op_of(w) != OP_SPECIAL) &&
             (op_of(w) != OP_BCOND);
   endfunction

   // Compares only update flags; every other ALU op writes Rdest
   function automatic logic writes_dest(input logic [15:0] w);
      return !(((op_of(w) == OP_RTYPE) && (ext_of(w) == EXT_CMP)) ||
               (op_of(w) == OP_CMPI));
   endfunction

   // State following DECODE, chosen from the word arriving on mem_dout
   function automatic state_t decode_target(input logic [15:0] w);
      state_t nxt;
      nxt = FETCH;
      if (op_of(w) == OP_RTYPE) begin
         nxt = is_wait(w) ? HALT : EXECUTE;
      end else if (op_of(w) == OP_BCOND) begin
         nxt = BRANCH;
      end else if (op_of(w) == OP_SPECIAL) begin
         if (is_load(w) || is_stor(w)) begin
            nxt = MEM;
         end else if (is_jcond(w)) begin
            nxt = BRANCH;
         end else begin
            nxt = FETCH;
         end
      end else begin
         nxt = EXECUTE;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the current
// flag register to a taken/not-taken decision. Undefined codes never branch.
module cond_eval
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] flags,
   output logic       taken
);

   // The F (overflow) flag has no branch condition of its own
   logic unused_flag_f;
   assign unused_flag_f = flags[FLAG_F];

   // Select the flag and polarity named by the condition code
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken =  flags[FLAG_Z];
         COND_NE: taken = !flags[FLAG_Z];
         COND_CS: taken =  flags[FLAG_C];
         COND_CC: taken = !flags[FLAG_C];
         COND_HI: taken =  flags[FLAG_L];
         COND_LS: taken = !flags[FLAG_L];
         COND_GT: taken =  flags[FLAG_N];
         COND_LE: taken = !flags[FLAG_N];
         COND_UC: taken =  1'b1;
         default: taken =  1'b0;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CR16-style datapath.
// Fetches from memory port A, latches the instruction register in DECODE
// and steps through EXECUTE / MEM / LOAD_WB / BRANCH, driving the datapath
// strobes from the registered state and instruction register.
module instr_sequencer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mem_dout,
   input  logic [4:0]  flags,
   output logic [15:0] ir,
   output logic [3:0]  mux_a_sel,
   output logic [3:0]  mux_b_sel,
   output logic [15:0] reg_en,
   output logic        imm_sel,
   output logic        wb_sel,
   output logic        flag_en,
   output logic        pc_en,
   output logic        pc_ld,
   output logic        pc_src,
   output logic        addr_sel,
   output logic        mem_w_en,
   output logic        halted,
   output logic [2:0]  state
);

   state_t cur_state;
   state_t next_state;
   logic   branch_taken;

   cond_eval u_cond_eval (
      .cond  (ir[11:8]),
      .flags (flags),
      .taken (branch_taken)
   );

   // Register selects come straight from the instruction fields
   assign mux_a_sel = ir[11:8];
   assign mux_b_sel = ir[3:0];
   assign state     = cur_state;

   // State register; reset always lands in FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= FETCH;
      end else begin
         cur_state <= next_state;
      end
   end

   // Instruction register captures the fetched word at the end of DECODE
   always_ff @(posedge clk) begin
      if (reset) begin
         ir <= 16'h0000;
      end else if (cur_state == DECODE) begin
         ir <= mem_dout;
      end
   end

   // Next-state logic; DECODE looks at mem_dout because ir is not yet loaded
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         FETCH:   next_state = DECODE;
         DECODE:  next_state = decode_target(mem_dout);
         EXECUTE: next_state = FETCH;
         MEM:     next_state = is_load(ir) ? LOAD_WB : FETCH;
         LOAD_WB: next_state = FETCH;
         BRANCH:  next_state = FETCH;
         HALT:    next_state = HALT;
         default: next_state = FETCH;
      endcase
   end

   // Output decode; every strobe is forced low while reset is asserted so an
   // in-flight store or write-back is dropped in the reset cycle itself
   always_comb begin
      reg_en   = 16'h0000;
      imm_sel  = 1'b0;
      wb_sel   = 1'b0;
      flag_en  = 1'b0;
      pc_en    = 1'b0;
      pc_ld    = 1'b0;
      pc_src   = 1'b0;
      addr_sel = 1'b0;
      mem_w_en = 1'b0;
      halted   = 1'b0;
      if (!reset) begin
         case (cur_state)
            DECODE: begin
               pc_en = 1'b1;
            end
            EXECUTE: begin
               imm_sel = is_imm_alu(ir);
               flag_en = 1'b1;
               if (writes_dest(ir)) begin
                  reg_en = onehot16(ir[11:8]);
               end
            end
            MEM: begin
               addr_sel = 1'b1;
               mem_w_en = is_stor(ir);
            end
            LOAD_WB: begin
               addr_sel = 1'b1;
               wb_sel   = 1'b1;
               reg_en   = onehot16(ir[11:8]);
            end
            BRANCH: begin
               if (branch_taken) begin
                  pc_ld  = 1'b1;
                  pc_src = is_jcond(ir);
               end
            end
            HALT: begin
               halted = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed vector table, hand-written reset and
// WAIT sequences, and randomized instructions checked against a reference
// model that predicts per-instruction strobe totals from the ISA rules.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] mem_dout;
   logic [4:0]  flags;
   logic [15:0] ir;
   logic [3:0]  mux_a_sel;
   logic [3:0]  mux_b_sel;
   logic [15:0] reg_en;
   logic        imm_sel;
   logic        wb_sel;
   logic        flag_en;
   logic        pc_en;
   logic        pc_ld;
   logic        pc_src;
   logic        addr_sel;
   logic        mem_w_en;
   logic        halted;
   logic [2:0]  state;

   int pass_count  = 0;
   int check_count = 0;

   // Expected per-instruction behaviour
   typedef struct {
      logic [15:0] instr;
      logic [4:0]  flg;
      int          cycles;
      logic [15:0] reg_en;
      bit          imm;
      bit          flag_en;
      bit          mem_w;
      bit          wb;
      bit          pc_ld;
      bit          pc_src;
      int          addr_cnt;
   } vec_t;

   // Observed per-instruction totals
   typedef struct {
      int          cycles;
      logic [15:0] reg_or;
      int          reg_pulses;
      bit          imm;
      int          flag_cnt;
      int          mem_w_cnt;
      int          mem_w_addr_cnt;
      bit          wb;
      int          pc_ld_cnt;
      bit          pc_src;
      int          addr_cnt;
      int          pc_en_cnt;
      int          conflict_cnt;
      bit          timeout;
   } obs_t;

   vec_t vecs[14];

   always #5 clk = ~clk;

   instr_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .mem_dout  (mem_dout),
      .flags     (flags),
      .ir        (ir),
      .mux_a_sel (mux_a_sel),
      .mux_b_sel (mux_b_sel),
      .reg_en    (reg_en),
      .imm_sel   (imm_sel),
      .wb_sel    (wb_sel),
      .flag_en   (flag_en),
      .pc_en     (pc_en),
      .pc_ld     (pc_ld),
      .pc_src    (pc_src),
      .addr_sel  (addr_sel),
      .mem_w_en  (mem_w_en),
      .halted    (halted),
      .state     (state)
   );

   // Global time bound in case the DUT or bench ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Behavioural model: what one whole instruction should do, from the ISA rules
   function automatic vec_t model(input logic [15:0] w, input logic [4:0] f);
      vec_t v;
      logic [3:0] op;
      logic [3:0] rd;
      logic [3:0] ext;
      bit t;
      v = '{default: 0};
      v.instr = w;
      v.flg   = f;
      op  = w[15:12];
      rd  = w[11:8];
      ext = w[7:4];
      if ((op == 4'h4 && ext == 4'hC) || op == 4'hC) begin
         case (rd)
            4'd0:    t =  f[1];
            4'd1:    t = !f[1];
            4'd2:    t =  f[4];
            4'd3:    t = !f[4];
            4'd4:    t =  f[3];
            4'd5:    t = !f[3];
            4'd12:   t =  f[0];
            4'd13:   t = !f[0];
            4'd14:   t =  1'b1;
            default: t =  1'b0;
         endcase
         v.cycles = 3;
         v.pc_ld  = t;
         v.pc_src = t && (op == 4'h4);
      end else if (op == 4'h4) begin
         if (ext == 4'h0) begin
            v.cycles   = 4;
            v.reg_en   = 16'h0001 << rd;
            v.wb       = 1'b1;
            v.addr_cnt = 2;
         end else if (ext == 4'h4) begin
            v.cycles   = 3;
            v.mem_w    = 1'b1;
            v.addr_cnt = 1;
         end else begin
            v.cycles = 2;
         end
      end else begin
         v.cycles  = 3;
         v.flag_en = 1'b1;
         v.imm     = (op != 4'h0);
         if ((op == 4'h0 && ext == 4'hB) || op == 4'hB) begin
            v.reg_en = 16'h0000;
         end else begin
            v.reg_en = 16'h0001 << rd;
         end
      end
      return v;
   endfunction

   // Run one instruction from FETCH back to FETCH, totalling the strobes seen
   task automatic apply_stimulus(input logic [15:0] instr, input logic [4:0] flg, output obs_t o);
      bit done;
      o = '{default: 0};
      done = 1'b0;
      mem_dout = instr;
      flags    = flg;
      #1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) begin
            tick();
            if (state == 3'd0) begin
               done = 1'b1;
               break;
            end
         end
         o.cycles++;
         o.reg_or = o.reg_or | reg_en;
         if (reg_en != 16'h0000) o.reg_pulses++;
         if (imm_sel) o.imm = 1'b1;
         if (flag_en) o.flag_cnt++;
         if (mem_w_en) o.mem_w_cnt++;
         if (mem_w_en && addr_sel) o.mem_w_addr_cnt++;
         if (wb_sel) o.wb = 1'b1;
         if (pc_ld) o.pc_ld_cnt++;
         if (pc_src) o.pc_src = 1'b1;
         if (addr_sel) o.addr_cnt++;
         if (pc_en) o.pc_en_cnt++;
         if (pc_en && pc_ld) o.conflict_cnt++;
      end
      if (!done) begin
         o.timeout = 1'b1;
         reset = 1'b1;
         tick();
         reset = 1'b0;
      end
   endtask

   task automatic check_output(input string tag, input vec_t v, input obs_t o);
      check($sformatf("%s %h timeout", tag, v.instr), 32'(o.timeout), 32'd0);
      check($sformatf("%s %h cycles", tag, v.instr), 32'(o.cycles), 32'(v.cycles));
      check($sformatf("%s %h reg_en", tag, v.instr), 32'(o.reg_or), 32'(v.reg_en));
      check($sformatf("%s %h reg_en pulses", tag, v.instr), 32'(o.reg_pulses), (v.reg_en != 0) ? 32'd1 : 32'd0);
      check($sformatf("%s %h imm_sel", tag, v.instr), 32'(o.imm), 32'(v.imm));
      check($sformatf("%s %h flag_en", tag, v.instr), 32'(o.flag_cnt), 32'(v.flag_en));
      check($sformatf("%s %h mem_w_en", tag, v.instr), 32'(o.mem_w_cnt), 32'(v.mem_w));
      check($sformatf("%s %h mem_w addr_sel", tag, v.instr), 32'(o.mem_w_addr_cnt), 32'(v.mem_w));
      check($sformatf("%s %h wb_sel", tag, v.instr), 32'(o.wb), 32'(v.wb));
      check($sformatf("%s %h pc_ld", tag, v.instr), 32'(o.pc_ld_cnt), 32'(v.pc_ld));
      check($sformatf("%s %h pc_src", tag, v.instr), 32'(o.pc_src), 32'(v.pc_src));
      check($sformatf("%s %h addr_sel", tag, v.instr), 32'(o.addr_cnt), 32'(v.addr_cnt));
      check($sformatf("%s %h pc_en", tag, v.instr), 32'(o.pc_en_cnt), 32'd1);
      check($sformatf("%s %h pc_en/pc_ld overlap", tag, v.instr), 32'(o.conflict_cnt), 32'd0);
   endtask

   function automatic logic [31:0] strobe_word();
      return {8'h00, reg_en, flag_en, pc_en, pc_ld, mem_w_en, imm_sel, wb_sel, pc_src, addr_sel};
   endfunction

   initial begin
      obs_t o;
      vec_t v;
      logic [15:0] w;
      logic [4:0]  f;
      int bad;

      // Directed vectors: instr, flags, cycles, reg_en, imm, flag_en, mem_w, wb, pc_ld, pc_src, addr_cnt
      vecs[0]  = '{16'h5305, 5'b00000, 3, 16'h0008, 1, 1, 0, 0, 0, 0, 0};
      vecs[1]  = '{16'h01B2, 5'b00000, 3, 16'h0000, 0, 1, 0, 0, 0, 0, 0};
      vecs[2]  = '{16'h4446, 5'b00000, 3, 16'h0000, 0, 0, 1, 0, 0, 0, 1};
      vecs[3]  = '{16'h4506, 5'b00000, 4, 16'h0020, 0, 0, 0, 1, 0, 0, 2};
      vecs[4]  = '{16'hC003, 5'b00010, 3, 16'h0000, 0, 0, 0, 0, 1, 0, 0};
      vecs[5]  = '{16'hC003, 5'b11101, 3, 16'h0000, 0, 0, 0, 0, 0, 0, 0};
      vecs[6]  = '{16'h4EC7, 5'b00000, 3, 16'h0000, 0, 0, 0, 0, 1, 1, 0};
      vecs[7]  = '{16'hB10A, 5'b00000, 3, 16'h0000, 1, 1, 0, 0, 0, 0, 0};
      vecs[8]  = '{16'h4130, 5'b00000, 2, 16'h0000, 0, 0, 0, 0, 0, 0, 0};
      vecs[9]  = '{16'h0215, 5'b00000, 3, 16'h0004, 0, 1, 0, 0, 0, 0, 0};
      vecs[10] = '{16'hC7FF, 5'b11111, 3, 16'h0000, 0, 0, 0, 0, 0, 0, 0};
      vecs[11] = '{16'h4DC2, 5'b00001, 3, 16'h0000, 0, 0, 0, 0, 0, 0, 0};
      vecs[12] = '{16'h4DC2, 5'b00000, 3, 16'h0000, 0, 0, 0, 0, 1, 1, 0};
      vecs[13] = '{16'h1F80, 5'b00000, 3, 16'h8000, 1, 1, 0, 0, 0, 0, 0};

      reset    = 1'b1;
      mem_dout = 16'h0000;
      flags    = 5'b00000;
      repeat (2) @(posedge clk);
      #2;
      check("reset state", 32'(state), 32'd0);
      check("reset ir", 32'(ir), 32'd0);
      check("reset strobes", strobe_word(), 32'd0);
      check("reset halted", 32'(halted), 32'd0);
      check("reset mux sels", {24'h0, mux_a_sel, mux_b_sel}, 32'd0);
      reset = 1'b0;

      $display("[TB] directed vector table");
      for (int i = 0; i < 14; i++) begin
         apply_stimulus(vecs[i].instr, vecs[i].flg, o);
         check_output("vec", vecs[i], o);
      end
      check("mux_a_sel after 4DC2/1F80", 32'(mux_a_sel), 32'hF);
      check("mux_b_sel after 1F80", 32'(mux_b_sel), 32'h0);

      $display("[TB] reset during MEM of LOAD");
      mem_dout = 16'h4506;
      #1;
      tick();
      tick();
      check("midload in MEM", 32'(state), 32'd3);
      reset = 1'b1;
      #1;
      check("midload strobes in reset cycle", strobe_word(), 32'd0);
      tick();
      check("midload state after edge", 32'(state), 32'd0);
      check("midload ir after edge", 32'(ir), 32'd0);
      check("midload reg_en after edge", 32'(reg_en), 32'd0);
      reset = 1'b0;

      $display("[TB] reset during MEM of STOR");
      mem_dout = 16'h4446;
      #1;
      tick();
      tick();
      check("midstor in MEM", 32'(state), 32'd3);
      reset = 1'b1;
      #1;
      check("midstor mem_w_en in reset cycle", 32'(mem_w_en), 32'd0);
      tick();
      check("midstor state after edge", 32'(state), 32'd0);
      reset = 1'b0;

      $display("[TB] randomized instructions against model");
      for (int i = 0; i < 300; i++) begin
         w = 16'($urandom);
         f = 5'($urandom);
         if (w[15:12] == 4'h0 && w[7:4] == 4'h0) w[7:4] = 4'h1;
         v = model(w, f);
         apply_stimulus(w, f, o);
         check_output("rand", v, o);
         check($sformatf("rand %h ir", w), 32'(ir), 32'(w));
      end

      $display("[TB] WAIT halts until reset");
      mem_dout = 16'h0000;
      #1;
      check("wait fetch state", 32'(state), 32'd0);
      tick();
      check("wait decode pc_en", 32'(pc_en), 32'd1);
      tick();
      check("wait halt state", 32'(state), 32'd6);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (halted !== 1'b1 || strobe_word() !== 32'd0 || state !== 3'd6) bad++;
         tick();
      end
      check("wait halted 20 cycles quiet", 32'(bad), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("wait reset to fetch", 32'(state), 32'd0);
      check("wait halted cleared", 32'(halted), 32'd0);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer for the 16-bit CR16-style datapath: register bank, A/B register muxes, ALU, flag register, dual-port memory and program counter. It fetches each instruction from memory port A, latches it into an instruction register and steps through execute, memory and branch states. In each state it drives the register-mux selects, one-hot register write enables, immediate/write-back selects, flag/PC enables and the memory write strobe. It replaces the purely combinational opcode-to-control path with a registered FSM.

## Interface
- No parameters. Widths are fixed: 16-bit word, 16 registers.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; one clock with reset high returns the block to FETCH
- mem_dout  in  16  memory port A read data; synchronous memory, valid one cycle after the address is presented
- flags  in  5  flag register contents {C,L,F,Z,N} on bits [4:0]
- ir  out  16  instruction register; reset 16'h0000
- mux_a_sel  out  4  = ir[11:8] (Rdest); reset 0
- mux_b_sel  out  4  = ir[3:0] (Rsrc / address / target register); reset 0
- reg_en  out  16  one-hot register write enable; reset 0
- imm_sel  out  1  1 = ALU B operand is ir[7:0] extended; reset 0
- wb_sel  out  1  0 = write ALU result, 1 = write mem_dout; reset 0
- flag_en  out  1  flag register load; reset 0
- pc_en  out  1  PC increment; reset 0
- pc_ld  out  1  PC load; reset 0
- pc_src  out  1  0 = PC+sext(ir[7:0]), 1 = register mux_b; reset 0
- addr_sel  out  1  memory address source: 0 = PC, 1 = register mux_b; reset 0
- mem_w_en  out  1  memory port A write strobe (data = register mux_a); reset 0
- halted  out  1  high in HALT; reset 0
- state  out  3  current state encoding, for debug; reset FETCH

## Operation
- **States:** FETCH, DECODE, EXECUTE, MEM, LOAD_WB, BRANCH, HALT.
- **FETCH:** addr_sel=0; always → DECODE.
- **DECODE:** ir ← mem_dout at the cycle end; pc_en=1 for exactly this cycle. Next state is chosen from mem_dout:
  - op 0000, ext 0000 (WAIT) → HALT
  - op 0000, other ext (reg-reg ALU) → EXECUTE
  - op in {0001,0010,0011,0101,0110,0111,1000,1001,1010,1011,1101,1110,1111} (immediate ALU) → EXECUTE
  - op 0100, ext 0000 (LOAD) or ext 0100 (STOR) → MEM
  - op 0100, ext 1100 (Jcond) or op 1100 (Bcond) → BRANCH
  - op 0100, any other ext → FETCH (no-op)
- **EXECUTE:**
  - imm_sel=1 for immediate ops.
  - flag_en=1.
  - reg_en = one-hot(ir[11:8]), except CMP (0000/1011) and CMPI (1011), which write no register.
  - → FETCH.
- **MEM:**
  - addr_sel=1.
  - STOR: mem_w_en=1, → FETCH.
  - LOAD: → LOAD_WB.
- **LOAD_WB:** addr_sel=1 held; wb_sel=1; reg_en=one-hot(ir[11:8]); → FETCH.
- **BRANCH:**
  - cond = ir[11:8]: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 HI L; 0101 LS !L; 1100 GT N; 1101 LE !N; 1110 UC 1; all others 0.
  - If taken: pc_ld=1, pc_src = 1 for Jcond, 0 for Bcond.
  - → FETCH.
- **HALT:** all strobes 0, halted=1; exits only via reset.
- **Strobe rules:**
  - All strobes (reg_en, flag_en, pc_en, pc_ld, mem_w_en) are single-cycle and decoded from the registered state and ir.
  - No strobe is active outside the states listed above.
  - At most one of pc_en and pc_ld is active in any cycle.

## Timing
- Cycles per instruction: ALU 3; STOR 3; LOAD 4; branch 3, taken or not; no-op 2.
- The Bcond displacement is relative to the already-incremented PC (the address of the instruction + 1).
- The flags sampled in BRANCH reflect every prior instruction, because flag_en is registered at the end of EXECUTE.
- Reset mid-instruction: the next state is FETCH, ir=0 and every strobe is 0 in the reset cycle.
  - A STOR or LOAD_WB in progress is aborted with no write.
  - The PC is reset by its own module on the same reset.

## Structure
- **Package cpu_pkg:**
  - state enum
  - opcode constants (OP_RTYPE=0000, OP_SPECIAL=0100, OP_BCOND=1100, OP_CMPI=1011)
  - ext constants (EXT_WAIT, EXT_LOAD, EXT_STOR, EXT_JCOND, EXT_CMP)
  - condition-code constants
  - flag bit indices
- **Sub-module cond_eval:** combinational; inputs cond[3:0] and flags[4:0]; output taken.
- **Main FSM:** state register plus next-state logic, with registered outputs where noted and the one-hot decode inline.

## Test plan
- **ADDI:** program ADDI R3,#5 (16'h5305) with R3=2 → EXECUTE asserts imm_sel=1, reg_en=16'h0008, flag_en=1; next FETCH 3 cycles after the first FETCH.
- **CMP:** program CMP R1,R2 (16'h01B2) → flag_en=1, reg_en=0 in EXECUTE.
- **STOR/LOAD:**
  - STOR R4,R6 (16'h4446) → mem_w_en high exactly 1 cycle with addr_sel=1.
  - A following LOAD R5,R6 (16'h4506) → LOAD_WB with wb_sel=1, reg_en=16'h0020; total 4 cycles.
- **Bcond EQ:**
  - BEQ +3 (16'hC003) with Z=1 → pc_ld=1, pc_src=0.
  - Same instruction with Z=0 → pc_ld=0.
  - JUC R7 (16'h4EC7) → pc_ld=1, pc_src=1.
- **WAIT:** WAIT (16'h0000) → halted=1 and stays there for 20 cycles with all strobes 0; reset pulse → FETCH next cycle.
- **Reset mid-LOAD:** reset asserted during MEM of a LOAD → no reg_en pulse, ir=0, state=FETCH after the edge.
